// File: rtl/sram_like_pkg.sv
// sram_like_pkg
// Shared definitions for the sram-like slave memory model:
//   size_e     - transfer size encoding carried on the size port
//   LFSR_SEED  - reset value of the optional back-pressure LFSR
//   lane_mask  - byte-lane enables from (size, addr[1:0])
package sram_like_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Size 3 is illegal and falls into the full-word case.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << a;
      SZ_HALF: lane_mask = a[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// sram_like_resp_fifo
// In-order response queue. Each entry carries a data word and a countdown
// loaded with LATENCY-1 on push; countdowns tick down every cycle and stop at 0.
// The head is ready once its countdown has reached 0.
// Ports:
//   clk, rst    - clock, synchronous active-high reset (empties the queue)
//   push        - enqueue push_data (caller guarantees room, or a same-cycle pop)
//   push_data   - word stored with the entry (read data, or 0 for writes)
//   pop         - dequeue the head (only when head_ready)
//   head_ready  - head valid and its countdown expired
//   head_data   - word of the head entry
//   count       - number of occupied entries
module sram_like_resp_fifo #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int LATENCY         = 1,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [31:0]      push_data,
  input  logic             pop,
  output logic             head_ready,
  output logic [31:0]      head_data,
  output logic [CNT_W-1:0] count
);

  localparam int          PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [3:0]  CD_LOAD = 4'(LATENCY - 1);

  logic [31:0]      data_q [MAX_OUTSTANDING];
  logic [3:0]       cd_q   [MAX_OUTSTANDING];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Every slot counts down, occupied or not; free slots are ignored via count.
  // When full with a same-cycle pop, wr_ptr equals rd_ptr and the new entry
  // simply overwrites the slot being retired.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (!rst && push && (PTR_W'(i) == wr_ptr)) begin
        data_q[i] <= push_data;
        cd_q[i]   <= CD_LOAD;
      end else if (cd_q[i] != 4'd0) begin
        cd_q[i] <= cd_q[i] - 4'd1;
      end
    end
  end

  assign head_ready = (count_q != '0) && (cd_q[rd_ptr] == 4'd0);
  assign head_data  = data_q[rd_ptr];
  assign count      = count_q;

endmodule

// File: rtl/sram_like_mem.sv
// sram_like_mem
// Simulation memory model serving one sram-like slave port with configurable
// response latency, multiple in-order outstanding transactions and optional
// random address-phase back-pressure. Contents live in `mem`, which benches
// may preload hierarchically; reset never clears it.
// Optional feature: define SRAM_LIKE_MEM_STALL_EN to enable LFSR-driven
// back-pressure on addr_ok (about one cycle in four).
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   req, wr   - request valid, 1 = write / 0 = read
//   size      - 0 byte, 1 halfword, 2 word (3 illegal, treated as word)
//   addr      - byte address; bits above the memory size are ignored
//   wdata     - lane-aligned write data
//   rdata     - full read word, valid only with data_ok (0 otherwise)
//   addr_ok   - address phase accepted when req is also high
//   data_ok   - one-cycle response for the oldest outstanding transaction
module sram_like_mem
  import sram_like_pkg::*;
#(
  parameter int DEPTH_WORDS     = 4096,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_ok,
  output logic        data_ok
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [3:0]       lanes;
  logic             stall;
  logic             accept;
  logic             head_ready;
  logic [31:0]      head_data;
  logic [31:0]      rd_word;
  logic [CNT_W-1:0] count;
  logic             unused_addr_hi;

  assign idx            = addr[2 +: IDX_W];
  assign unused_addr_hi = ^addr[31:2+IDX_W];
  assign lanes          = lane_mask(size, addr[1:0]);

  // Responses pending at reset are dropped, so data_ok is held off in the
  // reset cycle itself as well.
  assign data_ok = head_ready && !rst;
  assign rdata   = data_ok ? head_data : '0;
  // A full queue still accepts when the head retires in the same cycle.
  assign addr_ok = !rst && ((count < CNT_W'(MAX_OUTSTANDING)) || data_ok) && !stall;
  assign accept  = req && addr_ok;
  assign rd_word = wr ? '0 : mem[idx];

  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (lanes[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      assert (size != 2'b11)
        else $error("sram_like_mem: illegal size 3 at addr %h", addr);
    end
  end

  sram_like_resp_fifo #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .LATENCY         (LATENCY)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (accept),
    .push_data  (rd_word),
    .pop        (data_ok),
    .head_ready (head_ready),
    .head_data  (head_data),
    .count      (count)
  );

`ifdef SRAM_LIKE_MEM_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_sram_like_mem.sv
module tb_sram_like_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, c_rst;

  logic a_req, a_wr, a_addr_ok, a_data_ok;
  logic [1:0] a_size;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic b_req, b_wr, b_addr_ok, b_data_ok;
  logic [1:0] b_size;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic c_req, c_wr, c_addr_ok, c_data_ok;
  logic [1:0] c_size;
  logic [31:0] c_addr, c_wdata, c_rdata;

  sram_like_mem u_a (
    .clk(clk), .rst(rst), .req(a_req), .wr(a_wr), .size(a_size), .addr(a_addr),
    .wdata(a_wdata), .rdata(a_rdata), .addr_ok(a_addr_ok), .data_ok(a_data_ok));

  sram_like_mem #(.DEPTH_WORDS(16), .LATENCY(3), .MAX_OUTSTANDING(2)) u_b (
    .clk(clk), .rst(rst), .req(b_req), .wr(b_wr), .size(b_size), .addr(b_addr),
    .wdata(b_wdata), .rdata(b_rdata), .addr_ok(b_addr_ok), .data_ok(b_data_ok));

  sram_like_mem #(.LATENCY(4), .MAX_OUTSTANDING(4)) u_c (
    .clk(clk), .rst(c_rst), .req(c_req), .wr(c_wr), .size(c_size), .addr(c_addr),
    .wdata(c_wdata), .rdata(c_rdata), .addr_ok(c_addr_ok), .data_ok(c_data_ok));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // ---------------- reference model for u_b (LATENCY 3, 2 outstanding, 16 words)
  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;

  resp_t       bq[$];
  logic [31:0] bm [16];
  logic [15:0] m_lfsr;
  int          cyc;
  int          last_due;
  int          n_open = 0;
  int          n_low  = 0;

  function automatic bit in_lane(input logic [1:0] size, input logic [31:0] addr, input int b);
    int lo;
    lo = int'(addr % 4);
    case (size)
      2'd0:    return b == lo;
      2'd1:    return (b / 2) == (lo / 2);
      default: return 1'b1;
    endcase
  endfunction

  task automatic b_step(input logic req, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic accepted);
    logic        e_dok, e_aok, stall;
    logic [31:0] e_rd;
    int          k;
    resp_t       r;
    b_req = req; b_wr = wr; b_size = size; b_addr = addr; b_wdata = wdata;
    @(negedge clk);
    e_dok = (bq.size() > 0) && (bq[0].due == cyc);
    e_rd  = e_dok ? bq[0].data : 32'h0;
`ifdef SRAM_LIKE_MEM_STALL_EN
    stall = (m_lfsr % 4) == 0;
`else
    stall = 1'b0;
`endif
    e_aok = ((bq.size() < 2) || e_dok) && !stall;
    chk("b.addr_ok", 32'(b_addr_ok), 32'(e_aok));
    chk("b.data_ok", 32'(b_data_ok), 32'(e_dok));
    chk("b.rdata", b_rdata, e_rd);
    if ((bq.size() < 2) || e_dok) begin
      n_open++;
      if (b_addr_ok !== 1'b1) n_low++;
    end
    accepted = req && e_aok;
    @(posedge clk);
    if (e_dok) void'(bq.pop_front());
    if (accepted) begin
      k = int'((addr >> 2) % 16);
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (in_lane(size, addr, b)) bm[k][8*b +: 8] = wdata[8*b +: 8];
        r.data = 32'h0;
      end else begin
        r.data = bm[k];
      end
      r.due = (cyc + 3 > last_due + 1) ? cyc + 3 : last_due + 1;
      last_due = r.due;
      bq.push_back(r);
    end
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    cyc++;
    #1;
  endtask

  task automatic b_issue(input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
    logic acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 40) begin
      b_step(1'b1, wr, size, addr, wdata, acc);
      tries++;
    end
  endtask

  task automatic b_drain();
    logic acc;
    int   tries;
    tries = 0;
    while (bq.size() > 0 && tries < 40) begin
      b_step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, acc);
      tries++;
    end
    b_step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, acc);
  endtask

  // ---------------- directed cycle helpers for u_a and u_c
  task automatic a_cycle(input logic req, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic e_aok, input logic e_dok, input logic [31:0] e_rd,
                         input string tag);
    a_req = req; a_wr = wr; a_size = size; a_addr = addr; a_wdata = wdata;
    @(negedge clk);
    chk({tag, ".addr_ok"}, 32'(a_addr_ok), 32'(e_aok));
    chk({tag, ".data_ok"}, 32'(a_data_ok), 32'(e_dok));
    chk({tag, ".rdata"}, a_rdata, e_rd);
    @(posedge clk);
    #1;
  endtask

  task automatic c_cycle(input logic r, input logic req, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic e_aok, input string tag);
    c_rst = r; c_req = req; c_wr = wr; c_size = 2'd2; c_addr = addr; c_wdata = wdata;
    @(negedge clk);
    chk({tag, ".addr_ok"}, 32'(c_addr_ok), 32'(e_aok));
    chk({tag, ".data_ok"}, 32'(c_data_ok), 32'(1'b0));
    chk({tag, ".rdata"}, c_rdata, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [31:0] w;
    rst = 1'b1; c_rst = 1'b1;
    a_req = 0; a_wr = 0; a_size = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_wr = 0; b_size = 0; b_addr = 0; b_wdata = 0;
    c_req = 0; c_wr = 0; c_size = 0; c_addr = 0; c_wdata = 0;
    u_a.mem[4] = 32'h1122_3344;
    u_a.mem[0] = 32'h0;
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      u_b.mem[i] = w;
      bm[i] = w;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.a_addr_ok", 32'(a_addr_ok), 32'h0);
    chk("rst.a_data_ok", 32'(a_data_ok), 32'h0);
    chk("rst.a_rdata", a_rdata, 32'h0);
    chk("rst.b_addr_ok", 32'(b_addr_ok), 32'h0);
    chk("rst.b_data_ok", 32'(b_data_ok), 32'h0);
    chk("rst.c_addr_ok", 32'(c_addr_ok), 32'h0);
    chk("rst.c_rdata", c_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; c_rst = 1'b0;
    m_lfsr = 16'hACE1;
    cyc = 0;
    last_due = -100;

    // u_b: four back-to-back reads with only two slots
    for (int i = 0; i < 4; i++) b_issue(1'b0, 2'd2, 32'(i * 4), 32'h0);
    b_drain();

    // u_b: wrap-around of the 16-word array
    b_issue(1'b1, 2'd2, 32'h40, 32'hCAFE_F00D);
    b_issue(1'b0, 2'd2, 32'h0, 32'h0);
    b_drain();
    chk("wrap.mem0", u_b.mem[0], 32'hCAFE_F00D);

    // u_b: random traffic against the reference queue
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(3, 0) == 0) b_step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, acc);
      b_issue(1'($urandom_range(1, 0)), 2'($urandom_range(2, 0)), $urandom, $urandom);
    end
    b_drain();
`ifdef SRAM_LIKE_MEM_STALL_EN
    chk("stall.ratio", 32'((n_low * 100 >= n_open * 20) && (n_low * 100 <= n_open * 30)), 32'h1);
`else
    chk("nostall.low", 32'(n_low), 32'h0);

    // u_a: LATENCY 1 read of preloaded word
    a_cycle(1, 0, 2'd2, 32'h10, 32'h0, 1, 0, 32'h0, "a.rd");
    a_cycle(0, 0, 2'd0, 32'h0, 32'h0, 1, 1, 32'h1122_3344, "a.rd_resp");
    a_cycle(0, 0, 2'd0, 32'h0, 32'h0, 1, 0, 32'h0, "a.idle");
    // u_a: byte then halfword write, then word read
    a_cycle(1, 1, 2'd0, 32'h3, 32'hAA00_0000, 1, 0, 32'h0, "a.wb");
    a_cycle(1, 1, 2'd1, 32'h0, 32'h0000_BEEF, 1, 1, 32'h0, "a.wh");
    a_cycle(1, 0, 2'd2, 32'h0, 32'h0, 1, 1, 32'h0, "a.rdw");
    a_cycle(0, 0, 2'd0, 32'h0, 32'h0, 1, 1, 32'hAA00_BEEF, "a.rdw_resp");
    a_cycle(0, 0, 2'd0, 32'h0, 32'h0, 1, 0, 32'h0, "a.idle2");

    // u_c: reset with a read and a write in flight
    c_cycle(0, 1, 0, 32'h0, 32'h0, 1, "c.rd");
    c_cycle(0, 1, 1, 32'h20, 32'h5A5A_1234, 1, "c.wr");
    c_cycle(0, 0, 0, 32'h0, 32'h0, 1, "c.gap");
    c_cycle(1, 0, 0, 32'h0, 32'h0, 0, "c.rst");
    for (int i = 0; i < 6; i++) c_cycle(0, 0, 0, 32'h0, 32'h0, 1, "c.post");
    chk("c.mem_persist", u_c.mem[8], 32'h5A5A_1234);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
